// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 8 data bits, odd parity,
// stop and ack check, driving the open-drain clock/data pads through pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_START    = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_ACK_WAIT = 3'd4;
    localparam logic [2:0] S_RELEASE  = 3'd5;

    logic [2:0]    r_state;
    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_dat_s1, r_dat_s2;
    logic [7:0]    r_data;
    logic          r_par;
    logic [3:0]    r_n;
    logic [IW-1:0] r_inh_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_clk_oe, r_data_oe;
    logic          r_done, r_error;

    logic          w_fe;
    logic          w_accept;
    logic          w_in_frame;
    logic          w_timeout;
    logic [3:0]    w_n_next;
    logic [2:0]    w_bit_idx;

    assign w_fe       = r_clk_prev & ~r_clk_s2;
    assign w_accept   = tx_valid && (r_state == S_IDLE);
    assign w_in_frame = (r_state == S_SEND) || (r_state == S_ACK_WAIT) || (r_state == S_RELEASE);
    assign w_timeout  = (r_to_cnt >= TO_LAST);
    assign w_n_next   = r_n + 4'd1;
    assign w_bit_idx  = w_n_next[2:0] - 3'd1;

    // Pads idle high, so the synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_par     <= 1'b0;
            r_n       <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data    <= tx_data;
                        r_par     <= ~^tx_data;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == INH_LAST) begin
                        r_data_oe <= 1'b1;
                        r_state   <= S_START;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + IW'(1);
                    end
                end
                S_START: begin
                    r_clk_oe <= 1'b0;
                    r_n      <= '0;
                    r_to_cnt <= '0;
                    r_state  <= S_SEND;
                end
                S_SEND: begin
                    if (w_fe) begin
                        r_n <= w_n_next;
                        if (w_n_next <= 4'd8) begin
                            r_data_oe <= ~r_data[w_bit_idx];
                        end else if (w_n_next == 4'd9) begin
                            r_data_oe <= ~r_par;
                        end else begin
                            r_data_oe <= 1'b0;
                            r_state   <= S_ACK_WAIT;
                        end
                    end
                end
                S_ACK_WAIT: begin
                    if (w_fe) begin
                        if (r_dat_s2) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    if (r_clk_s2 && r_dat_s2) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // NOTE: the last non-blocking assignment wins, so a timeout overrides any
            // ack or done decision made by the case above in the same cycle.
            if (w_in_frame) begin
                if (w_timeout) begin
                    r_state   <= S_IDLE;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    r_done    <= 1'b0;
                    r_error   <= 1'b1;
                end else if (r_to_cnt != TO_MAX) begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end
        end
    end

    assign tx_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tx_done     = r_done;
    assign tx_error    = r_error;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames out of
// the host, and a monitor checks each done/error pulse against the queued expectation.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TOC = 2000;
    localparam int H   = 20;  // device clock half period in clk cycles (scaled down)

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_SILENT = 2;
    localparam int M_ABORT  = 3;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         mode;
    } exp_t;

    typedef struct {
        logic       start;
        logic [7:0] data;
        logic       par;
        logic       stop;
    } cap_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    exp_t exp_q[$];
    cap_t cap_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   n_pulse = 0;
    int   bfm_mode = M_ACK;
    logic bfm_fe4 = 1'b0;
    logic chk_low = 1'b0;

    assign ps2_clk_in  = !(ps2_clk_oe  || dev_clk_low);
    assign ps2_data_in = !(ps2_data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOC)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic ref_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2) == 0;
    endfunction

    // Device model: answers a host request by generating clock pulses and reading bits
    // on each rising edge, then acks (or not) on the 11th pulse.
    initial begin
        int   m;
        cap_t c;
        logic smp;
        logic aborted;
        forever begin
            @(negedge clk);
            if (!rst && ps2_clk_in && !ps2_data_in && !dev_data_low) begin
                m = bfm_mode;
                if (m == M_SILENT) begin
                    while (busy) @(negedge clk);
                end else begin
                    c.start = ps2_data_in;
                    aborted = 1'b0;
                    repeat (H) @(negedge clk);
                    for (int k = 1; k <= 10 && !aborted; k++) begin
                        dev_clk_low = 1'b1;
                        if (m == M_ABORT && k == 4) bfm_fe4 = 1'b1;
                        repeat (H) @(negedge clk);
                        dev_clk_low = 1'b0;
                        @(negedge clk);
                        smp = ps2_data_in;
                        if (k <= 8) c.data[k-1] = smp;
                        else if (k == 9) c.par = smp;
                        else c.stop = smp;
                        if (m == M_ABORT && k == 4) aborted = 1'b1;
                        repeat (H - 1) @(negedge clk);
                    end
                    if (!aborted) begin
                        cap_q.push_back(c);
                        if (m == M_ACK) begin
                            dev_data_low = 1'b1;
                            repeat (4) @(negedge clk);
                            dev_clk_low = 1'b1;
                            repeat (H) @(negedge clk);
                            dev_clk_low = 1'b0;
                            repeat (4) @(negedge clk);
                            dev_data_low = 1'b0;
                        end else begin
                            dev_clk_low = 1'b1;
                            repeat (H) @(negedge clk);
                            dev_clk_low = 1'b0;
                        end
                        repeat (H) @(negedge clk);
                    end
                end
            end
        end
    end

    // Monitor: every done/error pulse consumes one expectation from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        cap_t c;
        if (chk_low) begin
            check("pulse_width", {30'd0, tx_done, tx_error}, 32'd0);
            chk_low = 1'b0;
        end
        if (tx_done || tx_error) begin
            n_pulse++;
            chk_low = 1'b1;
            check("exclusive", tx_done & tx_error, 0);
            check("ready_on_pulse", tx_ready, 1);
            check("pulse_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("outcome_done", tx_done, e.mode == M_ACK);
                check("outcome_error", tx_error, e.mode != M_ACK);
                if (tx_error) check("released_on_err", {ps2_clk_oe, ps2_data_oe}, 0);
                if (e.mode != M_SILENT) begin
                    check("frame_captured", cap_q.size() != 0, 1);
                    if (cap_q.size() != 0) begin
                        c = cap_q.pop_front();
                        check("start_bit", c.start, 0);
                        check("data_byte", c.data, e.data);
                        check("parity_bit", c.par, e.par);
                        check("stop_bit", c.stop, 1);
                    end
                end
            end
        end
    end

    task automatic accept_now(input logic [7:0] d, input int m);
        exp_t e;
        tx_valid = 1'b1;
        tx_data  = d;
        bfm_mode = m;
        if (m != M_ABORT) begin
            e.data = d;
            e.par  = ref_parity(d);
            e.mode = m;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
    endtask

    task automatic check_inhibit();
        int cnt   = 0;
        int first = 0;
        @(negedge clk);
        check("inhibit_rise", ps2_clk_oe, 1);
        while (ps2_clk_oe && cnt < 1000) begin
            cnt++;
            if (ps2_data_oe && first == 0) first = cnt;
            @(negedge clk);
        end
        check("inhibit_len", cnt, INH + 1);
        check("start_cycle", first, INH + 1);
    endtask

    task automatic send(input logic [7:0] d, input int m);
        int t = 0;
        @(negedge clk);
        while (!tx_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", tx_ready, 1);
        accept_now(d, m);
        check_inhibit();
    endtask

    task automatic wait_pulse();
        int s;
        int t = 0;
        s = n_pulse;
        while (n_pulse == s && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("pulse_seen", n_pulse != s, 1);
    endtask

    initial begin
        int         t;
        int         cyc;
        int         p0;
        logic [7:0] d;
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_pulses", {tx_done, tx_error}, 0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("no_accept_in_rst", {busy, ps2_clk_oe}, 0);

        // 0xED with an ignored mid-frame request for 0x00
        send(8'hED, M_ACK);
        repeat (100) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        check("busy_not_ready", tx_ready, 0);
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        wait_pulse();
        @(negedge clk);
        check("ready_after_done", tx_ready, 1);

        // 0xF4, then 0xFF issued on the tx_done cycle
        send(8'hF4, M_ACK);
        t = 0;
        while (!(tx_done || tx_error) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("b2b_done_seen", tx_done, 1);
        check("b2b_ready", tx_ready, 1);
        accept_now(8'hFF, M_ACK);
        check_inhibit();
        wait_pulse();

        // No ack from the device
        send(8'($urandom), M_NOACK);
        wait_pulse();

        // Silent device: timeout measured from the first SEND cycle
        send(8'h3C, M_SILENT);
        cyc = 0;
        while (!tx_error && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, TOC);
        check("timeout_released", {ps2_clk_oe, ps2_data_oe}, 0);

        // Reset after the 4th falling edge
        bfm_fe4 = 1'b0;
        send(8'hA7, M_ABORT);
        t = 0;
        while (!bfm_fe4 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("abort_edge_seen", bfm_fe4, 1);
        repeat (5) @(negedge clk);
        p0  = n_pulse;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (3 * H) @(negedge clk);
        check("midrst_no_pulse", n_pulse - p0, 0);
        send(8'h01, M_ACK);
        wait_pulse();

        // Random bytes, mostly acked
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send(d, ($urandom_range(0, 3) == 0) ? M_NOACK : M_ACK);
            wait_pulse();
        end

        repeat (10) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
